hazard_controller: RTL and testbench

HAZARD_CONTROLLER -- requirements
Module: hazard_controller

---
 rtl/hazard_pkg.sv | 27 ++
 rtl/hazard_detect.sv | 62 ++++++
 rtl/hazard_controller.sv | 151 +++++++++++++++
 tb/tb_hazard_controller.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_HAZ   = 2'b01,
        ST_MWAIT = 2'b10,
        ST_FLUSH = 2'b11
    } state_t;

    typedef logic [1:0] fwd_sel_t;
    localparam fwd_sel_t FWD_RF  = 2'b00;
    localparam fwd_sel_t FWD_MEM = 2'b01;
    localparam fwd_sel_t FWD_WB  = 2'b10;

    typedef logic [1:0] stall_cnt_t;
    localparam stall_cnt_t STALL_NONE = 2'd0;
    localparam stall_cnt_t STALL_ONE  = 2'd1;
    localparam stall_cnt_t STALL_TWO  = 2'd2;

    // x0 is hardwired zero, so a write to it never creates a dependency.
    function automatic logic src_match(input logic use_src, input logic [4:0] rs,
                                       input logic [4:0] rd, input logic wen);
        return use_src && wen && (rd != 5'd0) && (rd == rs);
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational dependency check: required stall count and decode forward selects.
module hazard_detect
    import hazard_pkg::*;
(
    input  logic       dec_use1,
    input  logic       dec_use2,
    input  logic [4:0] dec_rs1,
    input  logic [4:0] dec_rs2,
    input  logic       dec_is_br,
    input  logic [4:0] ex_rd,
    input  logic       ex_wen,
    input  logic       ex_is_load,
    input  logic [4:0] mem_rd,
    input  logic       mem_wen,
    input  logic       mem_is_load,
    input  logic [4:0] wb_rd,
    input  logic       wb_wen,
    output stall_cnt_t stall_n,
    output fwd_sel_t   fwd_a_sel,
    output fwd_sel_t   fwd_b_sel
);

    function automatic stall_cnt_t src_need(input logic is_br, input logic ex_hit,
                                            input logic ex_ld, input logic mem_hit,
                                            input logic mem_ld);
        if (ex_hit && ex_ld)
            return is_br ? STALL_TWO : STALL_ONE;
        if (is_br && ex_hit)
            return STALL_ONE;
        if (is_br && mem_hit && mem_ld)
            return STALL_ONE;
        return STALL_NONE;
    endfunction

    // A MEM-stage load has no data yet, so only WB can serve that operand.
    function automatic fwd_sel_t src_fwd(input logic mem_hit, input logic mem_ld,
                                         input logic wb_hit);
        if (mem_hit && !mem_ld)
            return FWD_MEM;
        if (wb_hit)
            return FWD_WB;
        return FWD_RF;
    endfunction

    logic       ex_hit1, ex_hit2, mem_hit1, mem_hit2, wb_hit1, wb_hit2;
    stall_cnt_t need1, need2;

    assign ex_hit1  = src_match(dec_use1, dec_rs1, ex_rd, ex_wen);
    assign ex_hit2  = src_match(dec_use2, dec_rs2, ex_rd, ex_wen);
    assign mem_hit1 = src_match(dec_use1, dec_rs1, mem_rd, mem_wen);
    assign mem_hit2 = src_match(dec_use2, dec_rs2, mem_rd, mem_wen);
    assign wb_hit1  = src_match(dec_use1, dec_rs1, wb_rd, wb_wen);
    assign wb_hit2  = src_match(dec_use2, dec_rs2, wb_rd, wb_wen);

    assign need1   = src_need(dec_is_br, ex_hit1, ex_is_load, mem_hit1, mem_is_load);
    assign need2   = src_need(dec_is_br, ex_hit2, ex_is_load, mem_hit2, mem_is_load);
    assign stall_n = (need1 > need2) ? need1 : need2;

    assign fwd_a_sel = src_fwd(mem_hit1, mem_is_load, wb_hit1);
    assign fwd_b_sel = src_fwd(mem_hit2, mem_is_load, wb_hit2);

endmodule

// File: rtl/hazard_controller.sv
// Pipeline stall/flush/forward controller. Optional performance counters
// are built only when HAZARD_PERF_EN is defined.
module hazard_controller
    import hazard_pkg::*;
#(
    parameter int PERF_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [4:0]        dec_rs1,
    input  logic [4:0]        dec_rs2,
    input  logic              dec_use1,
    input  logic              dec_use2,
    input  logic              dec_is_br,
    input  logic [4:0]        ex_rd,
    input  logic [4:0]        mem_rd,
    input  logic [4:0]        wb_rd,
    input  logic              ex_wen,
    input  logic              mem_wen,
    input  logic              wb_wen,
    input  logic              ex_is_load,
    input  logic              mem_is_load,
    input  logic              npc_control,
    input  logic              dmem_busy,
    output logic              stall_if,
    output logic              stall_id,
    output logic              bubble_ex,
    output logic              stall_ex,
    output logic              stall_mem,
    output logic              flush_id,
    output logic              redirect_ok,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic [PERF_W-1:0] perf_stall,
    output logic [PERF_W-1:0] perf_flush,
    output logic [PERF_W-1:0] perf_mwait
);

    stall_cnt_t stall_n;

    hazard_detect u_detect (
        .dec_use1    (dec_use1),
        .dec_use2    (dec_use2),
        .dec_rs1     (dec_rs1),
        .dec_rs2     (dec_rs2),
        .dec_is_br   (dec_is_br),
        .ex_rd       (ex_rd),
        .ex_wen      (ex_wen),
        .ex_is_load  (ex_is_load),
        .mem_rd      (mem_rd),
        .mem_wen     (mem_wen),
        .mem_is_load (mem_is_load),
        .wb_rd       (wb_rd),
        .wb_wen      (wb_wen),
        .stall_n     (stall_n),
        .fwd_a_sel   (fwd_a_sel),
        .fwd_b_sel   (fwd_b_sel)
    );

    state_t     state, saved_state, eff_state;
    stall_cnt_t cnt, saved_cnt, eff_cnt;
    logic       hazard_run, haz_hold;

    // Once memory is ready, MWAIT behaves exactly as the interrupted state in the same cycle.
    assign eff_state = (state == ST_MWAIT) ? saved_state : state;
    assign eff_cnt   = (state == ST_MWAIT) ? saved_cnt : cnt;

    assign hazard_run  = (eff_state == ST_RUN) && (stall_n != STALL_NONE);
    assign haz_hold    = (eff_state == ST_HAZ);
    assign stall_id    = dmem_busy | hazard_run | haz_hold;
    assign stall_if    = stall_id;
    assign bubble_ex   = !dmem_busy && (hazard_run || haz_hold);
    assign stall_ex    = dmem_busy;
    assign stall_mem   = dmem_busy;
    assign flush_id    = !dmem_busy && (eff_state == ST_FLUSH);
    assign redirect_ok = npc_control && !stall_id && !dmem_busy;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_RUN;
            cnt         <= STALL_NONE;
            saved_state <= ST_RUN;
            saved_cnt   <= STALL_NONE;
        end else if (dmem_busy) begin
            state <= ST_MWAIT;
            if (state != ST_MWAIT) begin
                saved_state <= state;
                saved_cnt   <= cnt;
            end
        end else begin
            case (eff_state)
                ST_RUN: begin
                    if (stall_n == STALL_TWO) begin
                        state <= ST_HAZ;
                        cnt   <= STALL_ONE;
                    end else if (redirect_ok) begin
                        state <= ST_FLUSH;
                        cnt   <= STALL_NONE;
                    end else begin
                        state <= ST_RUN;
                        cnt   <= STALL_NONE;
                    end
                end
                ST_HAZ: begin
                    cnt   <= (eff_cnt > STALL_ONE) ? eff_cnt - STALL_ONE : STALL_NONE;
                    state <= (eff_cnt > STALL_ONE) ? ST_HAZ : ST_RUN;
                end
                ST_FLUSH: begin
                    state <= redirect_ok ? ST_FLUSH : ST_RUN;
                    cnt   <= STALL_NONE;
                end
                default: begin
                    state <= ST_RUN;
                    cnt   <= STALL_NONE;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_EN
    localparam logic [PERF_W-1:0] PERF_ONE = PERF_W'(1);

    logic [PERF_W-1:0] stall_q, flush_q, mwait_q;

    // Counters saturate at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            flush_q <= '0;
            mwait_q <= '0;
        end else begin
            if (stall_id && !dmem_busy && stall_q != '1)
                stall_q <= stall_q + PERF_ONE;
            if (flush_id && flush_q != '1)
                flush_q <= flush_q + PERF_ONE;
            if (dmem_busy && mwait_q != '1)
                mwait_q <= mwait_q + PERF_ONE;
        end
    end

    assign perf_stall = stall_q;
    assign perf_flush = flush_q;
    assign perf_mwait = mwait_q;
`else
    assign perf_stall = '0;
    assign perf_flush = '0;
    assign perf_mwait = '0;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: directed scenarios plus a randomized
// run against a stall-budget reference model.
module tb_hazard_controller;

    localparam int PERF_W = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [4:0]        dec_rs1, dec_rs2, ex_rd, mem_rd, wb_rd;
    logic              dec_use1, dec_use2, dec_is_br;
    logic              ex_wen, mem_wen, wb_wen, ex_is_load, mem_is_load;
    logic              npc_control, dmem_busy;
    logic              stall_if, stall_id, bubble_ex, stall_ex, stall_mem, flush_id, redirect_ok;
    logic [1:0]        fwd_a_sel, fwd_b_sel;
    logic [PERF_W-1:0] perf_stall, perf_flush, perf_mwait;

    int n_cmp = 0;
    int n_bad = 0;

    // Order: stall_if, stall_id, bubble_ex, stall_ex, stall_mem, flush_id, redirect_ok
    wire [6:0] ctl = {stall_if, stall_id, bubble_ex, stall_ex, stall_mem, flush_id, redirect_ok};

    localparam logic [6:0] C_IDLE  = 7'b0000000;
    localparam logic [6:0] C_HAZ   = 7'b1110000;
    localparam logic [6:0] C_BUSY  = 7'b1101100;
    localparam logic [6:0] C_FLUSH = 7'b0000010;
    localparam logic [6:0] C_REDIR = 7'b0000001;

    hazard_controller #(.PERF_W(PERF_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .dec_rs1     (dec_rs1),
        .dec_rs2     (dec_rs2),
        .dec_use1    (dec_use1),
        .dec_use2    (dec_use2),
        .dec_is_br   (dec_is_br),
        .ex_rd       (ex_rd),
        .mem_rd      (mem_rd),
        .wb_rd       (wb_rd),
        .ex_wen      (ex_wen),
        .mem_wen     (mem_wen),
        .wb_wen      (wb_wen),
        .ex_is_load  (ex_is_load),
        .mem_is_load (mem_is_load),
        .npc_control (npc_control),
        .dmem_busy   (dmem_busy),
        .stall_if    (stall_if),
        .stall_id    (stall_id),
        .bubble_ex   (bubble_ex),
        .stall_ex    (stall_ex),
        .stall_mem   (stall_mem),
        .flush_id    (flush_id),
        .redirect_ok (redirect_ok),
        .fwd_a_sel   (fwd_a_sel),
        .fwd_b_sel   (fwd_b_sel),
        .perf_stall  (perf_stall),
        .perf_flush  (perf_flush),
        .perf_mwait  (perf_mwait)
    );

    always #5 clk = ~clk;

    task automatic idle();
        dec_rs1 = '0; dec_rs2 = '0; dec_use1 = 0; dec_use2 = 0; dec_is_br = 0;
        ex_rd = '0; mem_rd = '0; wb_rd = '0;
        ex_wen = 0; mem_wen = 0; wb_wen = 0; ex_is_load = 0; mem_is_load = 0;
        npc_control = 0; dmem_busy = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        @(negedge clk);
        #1;
        n_cmp++;
        if (ctl !== C_IDLE || fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00) begin
            n_bad++;
            $display("FAIL reset_outputs: got ctl=%b fa=%b fb=%b expected ctl=%b fa=00 fb=00",
                     ctl, fwd_a_sel, fwd_b_sel, C_IDLE);
        end
        n_cmp++;
        if (perf_stall !== '0 || perf_flush !== '0 || perf_mwait !== '0) begin
            n_bad++;
            $display("FAIL reset_perf: got %0d/%0d/%0d expected 0/0/0", perf_stall, perf_flush, perf_mwait);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        n_cmp++;
        if (ctl !== C_IDLE) begin
            n_bad++;
            $display("FAIL post_reset_idle: got %b expected %b", ctl, C_IDLE);
        end
    endtask

    task automatic test_load_use();
        @(negedge clk);
        idle();
        ex_rd = 5; ex_wen = 1; ex_is_load = 1; dec_rs1 = 5; dec_use1 = 1;
        #1;
        n_cmp++;
        if (ctl !== C_HAZ) begin
            n_bad++;
            $display("FAIL load_use_stall: got %b expected %b", ctl, C_HAZ);
        end
        @(negedge clk);
        ex_rd = 0; ex_wen = 0; ex_is_load = 0; mem_rd = 5; mem_wen = 1; mem_is_load = 1;
        #1;
        n_cmp++;
        if (ctl !== C_IDLE || fwd_a_sel !== 2'b00) begin
            n_bad++;
            $display("FAIL load_use_release: got ctl=%b fa=%b expected ctl=%b fa=00", ctl, fwd_a_sel, C_IDLE);
        end
        @(negedge clk);
        idle();
    endtask

    task automatic test_branch_load();
        @(negedge clk);
        idle();
        ex_rd = 7; ex_wen = 1; ex_is_load = 1; dec_is_br = 1; dec_rs2 = 7; dec_use2 = 1;
        #1;
        n_cmp++;
        if (ctl !== C_HAZ) begin
            n_bad++;
            $display("FAIL br_load_stall1: got %b expected %b", ctl, C_HAZ);
        end
        @(negedge clk);
        ex_rd = 0; ex_wen = 0; ex_is_load = 0; mem_rd = 7; mem_wen = 1; mem_is_load = 1;
        #1;
        n_cmp++;
        if (ctl !== C_HAZ) begin
            n_bad++;
            $display("FAIL br_load_stall2: got %b expected %b", ctl, C_HAZ);
        end
        @(negedge clk);
        mem_rd = 0; mem_wen = 0; mem_is_load = 0; wb_rd = 7; wb_wen = 1;
        #1;
        n_cmp++;
        if (ctl !== C_IDLE || fwd_b_sel !== 2'b10) begin
            n_bad++;
            $display("FAIL br_load_release: got ctl=%b fb=%b expected ctl=%b fb=10", ctl, fwd_b_sel, C_IDLE);
        end
        @(negedge clk);
        idle();
    endtask

    task automatic test_branch_alu();
        @(negedge clk);
        idle();
        ex_rd = 3; ex_wen = 1; dec_is_br = 1; dec_rs1 = 3; dec_use1 = 1;
        #1;
        n_cmp++;
        if (ctl !== C_HAZ) begin
            n_bad++;
            $display("FAIL br_alu_stall: got %b expected %b", ctl, C_HAZ);
        end
        @(negedge clk);
        ex_rd = 0; ex_wen = 0; mem_rd = 3; mem_wen = 1;
        #1;
        n_cmp++;
        if (ctl !== C_IDLE || fwd_a_sel !== 2'b01) begin
            n_bad++;
            $display("FAIL br_alu_fwd_mem: got ctl=%b fa=%b expected ctl=%b fa=01", ctl, fwd_a_sel, C_IDLE);
        end
        wb_rd = 3; wb_wen = 1;
        #1;
        n_cmp++;
        if (fwd_a_sel !== 2'b01) begin
            n_bad++;
            $display("FAIL fwd_mem_over_wb: got %b expected 01", fwd_a_sel);
        end
        mem_wen = 0;
        #1;
        n_cmp++;
        if (fwd_a_sel !== 2'b10) begin
            n_bad++;
            $display("FAIL fwd_wb_only: got %b expected 10", fwd_a_sel);
        end
        @(negedge clk);
        idle();
    endtask

    task automatic test_redirect();
        @(negedge clk);
        idle();
        npc_control = 1;
        #1;
        n_cmp++;
        if (ctl !== C_REDIR) begin
            n_bad++;
            $display("FAIL redirect_ok: got %b expected %b", ctl, C_REDIR);
        end
        @(negedge clk);
        npc_control = 0;
        #1;
        n_cmp++;
        if (ctl !== C_FLUSH) begin
            n_bad++;
            $display("FAIL flush_pulse: got %b expected %b", ctl, C_FLUSH);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (ctl !== C_IDLE) begin
            n_bad++;
            $display("FAIL flush_one_cycle: got %b expected %b", ctl, C_IDLE);
        end
        @(negedge clk);
        ex_rd = 2; ex_wen = 1; ex_is_load = 1; dec_rs1 = 2; dec_use1 = 1; npc_control = 1;
        #1;
        n_cmp++;
        if (ctl !== C_HAZ) begin
            n_bad++;
            $display("FAIL hazard_beats_redirect: got %b expected %b", ctl, C_HAZ);
        end
        @(negedge clk);
        idle();
        #1;
        n_cmp++;
        if (ctl !== C_IDLE) begin
            n_bad++;
            $display("FAIL no_flush_after_hazard: got %b expected %b", ctl, C_IDLE);
        end
    endtask

    task automatic test_mwait();
        logic [PERF_W-1:0] s0, m0;
        @(negedge clk);
        idle();
        s0 = perf_stall;
        m0 = perf_mwait;
        ex_rd = 7; ex_wen = 1; ex_is_load = 1; dec_is_br = 1; dec_rs2 = 7; dec_use2 = 1;
        #1;
        n_cmp++;
        if (ctl !== C_HAZ) begin
            n_bad++;
            $display("FAIL mwait_enter_haz: got %b expected %b", ctl, C_HAZ);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            idle();
            dmem_busy = 1;
            #1;
            n_cmp++;
            if (ctl !== C_BUSY) begin
                n_bad++;
                $display("FAIL mwait_busy_%0d: got %b expected %b", i, ctl, C_BUSY);
            end
        end
        @(negedge clk);
        dmem_busy = 0;
        #1;
        n_cmp++;
        if (ctl !== C_HAZ) begin
            n_bad++;
            $display("FAIL mwait_resume_haz: got %b expected %b", ctl, C_HAZ);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (ctl !== C_IDLE) begin
            n_bad++;
            $display("FAIL mwait_done: got %b expected %b", ctl, C_IDLE);
        end
`ifdef HAZARD_PERF_EN
        n_cmp++;
        if (perf_mwait - m0 !== PERF_W'(3) || perf_stall - s0 !== PERF_W'(2)) begin
            n_bad++;
            $display("FAIL mwait_perf: got mwait+%0d stall+%0d expected mwait+3 stall+2",
                     perf_mwait - m0, perf_stall - s0);
        end
`else
        n_cmp++;
        if (perf_mwait !== '0 || perf_stall !== '0 || perf_flush !== '0 || m0 !== '0 || s0 !== '0) begin
            n_bad++;
            $display("FAIL perf_disabled: got %0d/%0d/%0d expected 0/0/0", perf_stall, perf_flush, perf_mwait);
        end
`endif
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        idle();
        npc_control = 1;
        @(negedge clk);
        npc_control = 0;
        #1;
        n_cmp++;
        if (ctl !== C_FLUSH) begin
            n_bad++;
            $display("FAIL rst_pre_flush: got %b expected %b", ctl, C_FLUSH);
        end
        rst_n = 0;
        #1;
        n_cmp++;
        if (flush_id !== 1'b0 || perf_stall !== '0 || perf_flush !== '0 || perf_mwait !== '0) begin
            n_bad++;
            $display("FAIL rst_async_flush: got flush=%b perf=%0d/%0d/%0d expected flush=0 perf=0/0/0",
                     flush_id, perf_stall, perf_flush, perf_mwait);
        end
        @(negedge clk);
        rst_n = 1;
        #1;
        n_cmp++;
        if (ctl !== C_IDLE) begin
            n_bad++;
            $display("FAIL rst_no_pending_flush: got %b expected %b", ctl, C_IDLE);
        end
        @(negedge clk);
        dmem_busy = 1;
        @(negedge clk);
        rst_n = 0;
        dmem_busy = 0;
        #1;
        @(negedge clk);
        rst_n = 1;
        ex_rd = 0; ex_wen = 1; ex_is_load = 1; dec_is_br = 1; dec_rs1 = 0; dec_use1 = 1;
        #1;
        n_cmp++;
        if (ctl !== C_IDLE) begin
            n_bad++;
            $display("FAIL rst_mwait_x0: got %b expected %b", ctl, C_IDLE);
        end
        @(negedge clk);
        idle();
    endtask

    // Reference: a hazard owes N stall cycles; a redirect owes one flush cycle;
    // busy memory freezes whatever is owed.
    task automatic test_random();
        int rem = 0;
        bit flush_pend = 0;
        int exp_st = 0, exp_fl = 0, exp_mw = 0;
        @(negedge clk);
        idle();
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        for (int cyc = 0; cyc < 600; cyc++) begin
            logic [6:0] exp_ctl;
            logic [1:0] exp_fa, exp_fb;
            int n1, n2, n;
            bit e1, e2, m1, m2, w1, w2;
            @(negedge clk);
            dec_rs1 = 5'($urandom_range(0, 3));  dec_rs2 = 5'($urandom_range(0, 3));
            ex_rd   = 5'($urandom_range(0, 3));  mem_rd  = 5'($urandom_range(0, 3));
            wb_rd   = 5'($urandom_range(0, 3));
            dec_use1 = 1'($urandom);  dec_use2 = 1'($urandom);  dec_is_br = 1'($urandom);
            ex_wen = 1'($urandom);    mem_wen = 1'($urandom);   wb_wen = 1'($urandom);
            ex_is_load = 1'($urandom); mem_is_load = 1'($urandom);
            npc_control = ($urandom_range(0, 99) < 30);
            dmem_busy   = ($urandom_range(0, 99) < 15);

            e1 = dec_use1 && ex_wen  && ex_rd  != 0 && ex_rd  == dec_rs1;
            e2 = dec_use2 && ex_wen  && ex_rd  != 0 && ex_rd  == dec_rs2;
            m1 = dec_use1 && mem_wen && mem_rd != 0 && mem_rd == dec_rs1;
            m2 = dec_use2 && mem_wen && mem_rd != 0 && mem_rd == dec_rs2;
            w1 = dec_use1 && wb_wen  && wb_rd  != 0 && wb_rd  == dec_rs1;
            w2 = dec_use2 && wb_wen  && wb_rd  != 0 && wb_rd  == dec_rs2;
            n1 = (!dec_is_br) ? int'(e1 && ex_is_load)
                              : (e1 ? (ex_is_load ? 2 : 1) : int'(m1 && mem_is_load));
            n2 = (!dec_is_br) ? int'(e2 && ex_is_load)
                              : (e2 ? (ex_is_load ? 2 : 1) : int'(m2 && mem_is_load));
            n = (n1 > n2) ? n1 : n2;
            exp_fa = (m1 && !mem_is_load) ? 2'b01 : (w1 ? 2'b10 : 2'b00);
            exp_fb = (m2 && !mem_is_load) ? 2'b01 : (w2 ? 2'b10 : 2'b00);

            if (dmem_busy) begin
                exp_ctl = C_BUSY;
                exp_mw++;
            end else if (flush_pend) begin
                exp_ctl = C_FLUSH | (npc_control ? C_REDIR : C_IDLE);
                flush_pend = npc_control;
                exp_fl++;
            end else if (rem > 0) begin
                exp_ctl = C_HAZ;
                rem--;
                exp_st++;
            end else if (n > 0) begin
                exp_ctl = C_HAZ;
                rem = n - 1;
                exp_st++;
            end else begin
                exp_ctl = npc_control ? C_REDIR : C_IDLE;
                flush_pend = npc_control;
            end
            #1;
            n_cmp++;
            if (ctl !== exp_ctl || fwd_a_sel !== exp_fa || fwd_b_sel !== exp_fb) begin
                n_bad++;
                $display("FAIL random_cycle_%0d: got ctl=%b fa=%b fb=%b expected ctl=%b fa=%b fb=%b",
                         cyc, ctl, fwd_a_sel, fwd_b_sel, exp_ctl, exp_fa, exp_fb);
            end
        end
        @(negedge clk);
        idle();
        #1;
        n_cmp++;
`ifdef HAZARD_PERF_EN
        if (perf_stall !== PERF_W'(exp_st) || perf_flush !== PERF_W'(exp_fl) || perf_mwait !== PERF_W'(exp_mw)) begin
            n_bad++;
            $display("FAIL random_perf: got %0d/%0d/%0d expected %0d/%0d/%0d",
                     perf_stall, perf_flush, perf_mwait, exp_st, exp_fl, exp_mw);
        end
`else
        if (perf_stall !== '0 || perf_flush !== '0 || perf_mwait !== '0) begin
            n_bad++;
            $display("FAIL random_perf_off: got %0d/%0d/%0d expected 0/0/0 (model %0d/%0d/%0d)",
                     perf_stall, perf_flush, perf_mwait, exp_st, exp_fl, exp_mw);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch_load();
        test_branch_alu();
        test_redirect();
        test_mwait();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
